ttl_nibble_serial_adder: RTL and testbench

//  - Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit 74x283-style slice.
//  - Processes one nibble per clock, LSB nibble first, with the carry held in a flip-flop between nibbles.
//  - Datapath ALU successor to the single-chip 4-bit adder; trades latency for chip count.
//  - Start/busy/done handshake to the CPU sequencer.

---
 rtl/ttl_nibble_serial_adder.sv | 130 +++++++++++++
 tb/tb_ttl_nibble_serial_adder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit slice, LSB nibble first.
// Define TTL_NSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module ttl_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef TTL_NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW+1:0]    nib_sh;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       nib_sum;
`ifdef TTL_NSA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic [3:0]       low_sum;
`endif

  // Current slice operands are selected by the nibble counter.
  assign nib_sh  = {cnt_q, 2'b00};
  assign a_nib   = 4'(a_q >> nib_sh);
  assign b_nib   = 4'(b_q >> nib_sh);
  assign nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
`ifdef TTL_NSA_OVERFLOW_EN
  // Carry into the MSB of the slice, needed for the overflow flag.
  assign low_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef TTL_NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef TTL_NSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef TTL_NSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction as a + ~b + ~cin so the same slice serves both.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d  = (work_q & ~(WIDTH'(4'hF) << nib_sh))
                | (WIDTH'(nib_sum[3:0]) << nib_sh);
        carry_d = nib_sum[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NSLICE - 1)) begin
          // Visible result only changes here; it holds through the next RUN.
          sum_d   = work_d;
          cout_d  = nib_sum[4];
`ifdef TTL_NSA_OVERFLOW_EN
          ovf_d   = low_sum[3] ^ nib_sum[4];
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef TTL_NSA_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_ttl_nibble_serial_adder.sv
// Bench for ttl_nibble_serial_adder: WIDTH=16 and WIDTH=4 instances, vector table,
// directed multi-cycle sequences and random operations against an arithmetic model.
module tb_ttl_nibble_serial_adder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        st16, sub16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        st4, sub4, cin4, busy4, done4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef TTL_NSA_OVERFLOW_EN
  logic        ovf16, ovf4;
`endif

  ttl_nibble_serial_adder #(.WIDTH(16)) u16 (
    .clock(clock), .reset_n(reset_n), .start(st16), .sub(sub16), .a(a16), .b(b16),
    .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef TTL_NSA_OVERFLOW_EN
    , .ovf(ovf16)
`endif
  );

  ttl_nibble_serial_adder #(.WIDTH(4)) u4 (
    .clock(clock), .reset_n(reset_n), .start(st4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef TTL_NSA_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_s16 = '0, prev_s4 = '0;
  logic        prev_c16 = 1'b0, prev_c4 = 1'b0;

  typedef struct {
    logic [15:0] a, b;
    logic        sb, c;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic o_busy(input int w);
    return (w == 16) ? busy16 : busy4;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 16) ? done16 : done4;
  endfunction
  function automatic logic [15:0] o_sum(input int w);
    return (w == 16) ? sum16 : {12'h000, sum4};
  endfunction
  function automatic logic o_cout(input int w);
    return (w == 16) ? cout16 : cout4;
  endfunction
`ifdef TTL_NSA_OVERFLOW_EN
  function automatic logic o_ovf(input int w);
    return (w == 16) ? ovf16 : ovf4;
  endfunction
`endif

  task automatic drive(input int w, input logic s, input logic sb, input logic [15:0] a,
                       input logic [15:0] b, input logic c);
    if (w == 16) begin
      st16 = s; sub16 = sb; a16 = a; b16 = b; cin16 = c;
    end else begin
      st4 = s; sub4 = sb; a4 = a[3:0]; b4 = b[3:0]; cin4 = c;
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout, signed for overflow.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic sb, input logic c, output logic [15:0] s,
                       output logic co, output logic ov);
    longint mask, half, ax, bx, cx, r, sa, sbv, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ax = longint'(a) & mask;
    bx = longint'(b) & mask;
    cx = c ? 1 : 0;
    r  = sb ? (ax - bx - cx) : (ax + bx + cx);
    s  = 16'(r & mask);
    co = sb ? (r >= 0) : (r > mask);
    sa  = (ax >= half) ? ax - (mask + 1) : ax;
    sbv = (bx >= half) ? bx - (mask + 1) : bx;
    sr  = sb ? (sa - sbv - cx) : (sa + sbv + cx);
    ov  = (sr < -half) || (sr > half - 1);
  endtask

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic sb, input logic c, input logic [15:0] es,
                        input logic ec, input logic eo, input string nm);
    int ns;
    logic [15:0] ps;
    logic pc;
    ns = w / 4;
    ps = (w == 16) ? prev_s16 : prev_s4;
    pc = (w == 16) ? prev_c16 : prev_c4;
    @(negedge clock);
    drive(w, 1'b1, sb, a, b, c);
    @(negedge clock);
    drive(w, 1'b0, ~sb, ~a, ~b, ~c);
    chk({nm, " held sum"}, 32'(o_sum(w)), 32'(ps));
    chk({nm, " held cout"}, 32'(o_cout(w)), 32'(pc));
    for (int i = 0; i < ns; i++) begin
      if (i > 0) @(negedge clock);
      chk({nm, " busy"}, 32'(o_busy(w)), 32'd1);
      chk({nm, " done early"}, 32'(o_done(w)), 32'd0);
    end
    @(negedge clock);
    chk({nm, " busy end"}, 32'(o_busy(w)), 32'd0);
    chk({nm, " done"}, 32'(o_done(w)), 32'd1);
    chk({nm, " sum"}, 32'(o_sum(w)), 32'(es));
    chk({nm, " cout"}, 32'(o_cout(w)), 32'(ec));
`ifdef TTL_NSA_OVERFLOW_EN
    chk({nm, " ovf"}, 32'(o_ovf(w)), 32'(eo));
`else
    if (eo === 1'bx) chk({nm, " ovf x"}, 32'(eo), 32'd0);
`endif
    @(negedge clock);
    chk({nm, " done pulse"}, 32'(o_done(w)), 32'd0);
    chk({nm, " sum hold"}, 32'(o_sum(w)), 32'(es));
    if (w == 16) begin
      prev_s16 = es; prev_c16 = ec;
    end else begin
      prev_s4 = es; prev_c4 = ec;
    end
  endtask

  initial begin
    logic [15:0] ra, rb, ms;
    logic        rs, rc, mc, mo;
    int          dones;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[8] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    reset_n = 1'b0;
    drive(16, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(4, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clock);
    chk("reset busy", 32'(busy16), 32'd0);
    chk("reset done", 32'(done16), 32'd0);
    chk("reset sum", 32'(sum16), 32'd0);
    chk("reset cout", 32'(cout16), 32'd0);
`ifdef TTL_NSA_OVERFLOW_EN
    chk("reset ovf", 32'(ovf16), 32'd0);
`endif
    chk("reset busy4", 32'(busy4), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(16, tbl[i].a, tbl[i].b, tbl[i].sb, tbl[i].c, tbl[i].es, tbl[i].ec,
             tbl[i].eo, $sformatf("vec%0d", i));

    // start held high through RUN/DONE, inputs disturbed mid-run
    @(negedge clock);
    drive(16, 1'b1, 1'b0, 16'h0F0F, 16'h1111, 1'b0);
    dones = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (i == 1) drive(16, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1);
      if (i == 4) drive(16, 1'b1, 1'b0, 16'h0F0F, 16'h1111, 1'b0);
      if (done16) dones++;
      chk($sformatf("hold busy c%0d", i), 32'(busy16), (i <= 4) ? 32'd1 : 32'd0);
      if (i == 5) chk("hold sum", 32'(sum16), 32'h2020);
    end
    chk("hold one done", 32'(dones), 32'd1);
    @(negedge clock);
    chk("hold restart busy", 32'(busy16), 32'd1);
    drive(16, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clock);
    chk("hold restart busy4", 32'(busy16), 32'd1);
    @(negedge clock);
    chk("hold restart done", 32'(done16), 32'd1);
    chk("hold restart sum", 32'(sum16), 32'h2020);
    prev_s16 = 16'h2020; prev_c16 = 1'b0;

    // abort by reset in RUN cycle 2
    @(negedge clock);
    drive(16, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clock);
    drive(16, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clock);
    chk("abort pre busy", 32'(busy16), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy16), 32'd0);
    chk("abort done", 32'(done16), 32'd0);
    chk("abort sum", 32'(sum16), 32'd0);
    chk("abort cout", 32'(cout16), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clock);
      if (done16) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    chk("abort sum stays", 32'(sum16), 32'd0);
    prev_s16 = '0; prev_c16 = 1'b0; prev_s4 = '0; prev_c4 = 1'b0;

    run_op(4, 16'hF, 16'h1, 1'b0, 1'b1, 16'h1, 1'b1, 1'b0, "w4 F+1+1");

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      model(16, ra, rb, rs, rc, ms, mc, mo);
      run_op(16, ra, rb, rs, rc, ms, mc, mo, $sformatf("rnd16 %0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      model(4, ra, rb, rs, rc, ms, mc, mo);
      run_op(4, ra, rb, rs, rc, ms, mc, mo, $sformatf("rnd4 %0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
